// File: rtl/key_repeat_ctrl.sv
// key_repeat_ctrl: turns the raw HID keycode from the SoC PIO into one-cycle
// game command pulses. Movement keys auto-repeat (delayed auto-shift) with
// frame timing taken from the falling edge of the active-low VGA vsync.
// Rotate and hard-drop fire once per press.
module key_repeat_ctrl #(
  parameter int DAS_FRAMES = 10,  // frames from press to first repeat (1..63)
  parameter int ARR_FRAMES = 3    // frames between later repeats (1..63)
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       vs,
  output logic       move_left,
  output logic       move_right,
  output logic       move_down,
  output logic       rotate,
  output logic       hard_drop,
  output logic [4:0] held
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    ONESHOT
  } state_t;

  // Key indices; bit (index-1) of the pulse/held vectors belongs to each key.
  localparam logic [2:0] K_NONE  = 3'd0;
  localparam logic [2:0] K_LEFT  = 3'd1;
  localparam logic [2:0] K_RIGHT = 3'd2;
  localparam logic [2:0] K_DOWN  = 3'd3;
  localparam logic [2:0] K_ROT   = 3'd4;
  localparam logic [2:0] K_DROP  = 3'd5;

  localparam logic [5:0] DAS_LIMIT = 6'(DAS_FRAMES);
  localparam logic [5:0] ARR_LIMIT = 6'(ARR_FRAMES);

  state_t     state;
  logic [2:0] cur_key;
  logic [5:0] frame_cnt;
  logic [4:0] pulse;
  logic       vs_q1;
  logic       vs_q2;
  logic       tick;
  logic [2:0] key_idx;

  // One-hot decode of a key index; zero for "no key".
  function automatic logic [4:0] decode(input logic [2:0] idx);
    decode = (idx == K_NONE) ? 5'b0 : (5'b00001 << (idx - 3'd1));
  endfunction

  // Map the raw keycode to a key index.
  // NOTE: key_idx gets its default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch for unlisted codes.
  always_comb begin
    key_idx = K_NONE;
    case (keycode)
      8'h04:   key_idx = K_LEFT;
      8'h07:   key_idx = K_RIGHT;
      8'h16:   key_idx = K_DOWN;
      8'h1A:   key_idx = K_ROT;
      8'h2C:   key_idx = K_DROP;
      default: key_idx = K_NONE;
    endcase
  end

  // Two-stage vsync delay; the idle level of vsync is high.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its neighbours, which is what makes this a shift chain.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vs_q1 <= 1'b1;
      vs_q2 <= 1'b1;
    end else begin
      vs_q1 <= vs;
      vs_q2 <= vs_q1;
    end
  end

  // One cycle per falling edge of vsync marks a new frame.
  assign tick = vs_q2 & ~vs_q1;

  // Press / repeat FSM with registered pulse and held outputs. A key change
  // is checked before the frame tick so a new press always wins.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cur_key   <= K_NONE;
      frame_cnt <= 6'd0;
      pulse     <= 5'b0;
      held      <= 5'b0;
    end else begin
      pulse <= 5'b0;
      if (key_idx != K_NONE && (state == IDLE || key_idx != cur_key)) begin
        state     <= (key_idx == K_ROT || key_idx == K_DROP) ? ONESHOT : DELAY;
        cur_key   <= key_idx;
        frame_cnt <= 6'd0;
        pulse     <= decode(key_idx);
        held      <= decode(key_idx);
      end else if (key_idx == K_NONE && state != IDLE) begin
        state     <= IDLE;
        cur_key   <= K_NONE;
        frame_cnt <= 6'd0;
        held      <= 5'b0;
      end else if (tick) begin
        case (state)
          DELAY: begin
            if (frame_cnt + 6'd1 == DAS_LIMIT) begin
              pulse     <= decode(cur_key);
              frame_cnt <= 6'd0;
              state     <= REPEAT;
            end else begin
              frame_cnt <= frame_cnt + 6'd1;
            end
          end
          REPEAT: begin
            if (frame_cnt + 6'd1 == ARR_LIMIT) begin
              pulse     <= decode(cur_key);
              frame_cnt <= 6'd0;
            end else begin
              frame_cnt <= frame_cnt + 6'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign move_left  = pulse[0];
  assign move_right = pulse[1];
  assign move_down  = pulse[2];
  assign rotate     = pulse[3];
  assign hard_drop  = pulse[4];

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Bench for key_repeat_ctrl: directed stimulus pushes expected pulses
// (cycle + one-hot vector) into per-DUT queues; a negedge monitor pops and
// compares every pulse the DUTs present, and flags overdue expectations.
module tb_key_repeat_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] keycode = 8'h04;
  logic [7:0] key2 = 8'h00;
  logic       vs = 1'b1;

  logic ml1, mr1, md1, rot1, hd1;
  logic [4:0] h1;
  logic ml2, mr2, md2, rot2, hd2;
  logic [4:0] h2;

  key_repeat_ctrl dut (
    .Clk(clk), .Reset_n(rst_n), .keycode(keycode), .vs(vs),
    .move_left(ml1), .move_right(mr1), .move_down(md1),
    .rotate(rot1), .hard_drop(hd1), .held(h1)
  );

  key_repeat_ctrl #(.DAS_FRAMES(1), .ARR_FRAMES(1)) dut_fast (
    .Clk(clk), .Reset_n(rst_n), .keycode(key2), .vs(vs),
    .move_left(ml2), .move_right(mr2), .move_down(md2),
    .rotate(rot2), .hard_drop(hd2), .held(h2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         cyc;
    logic [4:0] pulses;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expect_pulse(input int u, input int at, input logic [4:0] p);
    exp_t e;
    e.cyc    = at;
    e.pulses = p;
    if (u == 1) q1.push_back(e);
    else        q2.push_back(e);
  endtask

  // Compare one DUT's pulse outputs against the head of its queue.
  task automatic mon(input int u, input logic [4:0] p, input logic [4:0] h);
    exp_t e;
    int   sz;
    sz = (u == 1) ? q1.size() : q2.size();
    e.cyc    = 0;
    e.pulses = 5'b0;
    if (sz > 0) e = (u == 1) ? q1[0] : q2[0];
    if (p != 5'b0) begin
      n_vec++;
      if (sz == 0) begin
        n_fail++;
        $display("FAIL dut%0d unexpected_pulse: got pulses=%b held=%b at cycle %0d, expected no pulse",
                 u, p, h, cyc);
      end else begin
        if (u == 1) void'(q1.pop_front());
        else        void'(q2.pop_front());
        if (p !== e.pulses || h !== e.pulses || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL dut%0d pulse: got pulses=%b held=%b at cycle %0d, expected pulses=%b held=%b at cycle %0d",
                   u, p, h, cyc, e.pulses, e.pulses, e.cyc);
        end
      end
    end else if (sz > 0 && e.cyc <= cyc) begin
      n_vec++;
      n_fail++;
      $display("FAIL dut%0d missing_pulse: got none at cycle %0d, expected pulses=%b at cycle %0d",
               u, cyc, e.pulses, e.cyc);
      if (u == 1) void'(q1.pop_front());
      else        void'(q2.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(1, {hd1, rot1, md1, mr1, ml1}, h1);
    mon(2, {hd2, rot2, md2, mr2, ml2}, h2);
  end

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // New keycode for the main DUT; the pulse is due after the next edge.
  task automatic press(input logic [7:0] k, input logic [4:0] exp_p);
    keycode = k;
    if (exp_p != 5'b0) expect_pulse(1, cyc + 1, exp_p);
    step(1);
  endtask

  // One 6-cycle frame: vsync low 2 cycles, high 4. A tick-driven pulse
  // appears two edges after vsync is driven low.
  task automatic frame(input logic [4:0] e1, input logic [4:0] e2);
    vs = 1'b0;
    if (e1 != 5'b0) expect_pulse(1, cyc + 2, e1);
    if (e2 != 5'b0) expect_pulse(2, cyc + 2, e2);
    step(2);
    vs = 1'b1;
    step(4);
  endtask

  // Frame whose tick coincides with a key change on the main DUT.
  task automatic frame_switch(input logic [7:0] k, input logic [4:0] exp_p);
    vs = 1'b0;
    step(1);
    keycode = k;
    expect_pulse(1, cyc + 1, exp_p);
    step(1);
    vs = 1'b1;
    step(4);
  endtask

  initial begin
    // Reset held low for three edges with A pressed: outputs stay quiet.
    repeat (3) begin
      @(negedge clk);
      check("reset_quiet", int'({hd1, rot1, md1, mr1, ml1, h1}), 0);
    end
    rst_n = 1'b1;
    expect_pulse(1, cyc + 1, 5'b00001);
    step(1);
    check("held_after_reset", int'(h1), 1);
    keycode = 8'h00;
    step(2);
    check("held_released", int'(h1), 0);

    // Auto-repeat of D with default DAS=10 / ARR=3.
    press(8'h07, 5'b00010);
    for (int f = 1; f <= 20; f++)
      frame((f == 10 || f == 13 || f == 16 || f == 19) ? 5'b00010 : 5'b00000, 5'b0);
    check("held_right", int'(h1), 5'b00010);
    keycode = 8'h00;
    step(2);
    check("held_after_right", int'(h1), 0);

    // Hard drop fires once per press.
    press(8'h2C, 5'b10000);
    for (int f = 1; f <= 30; f++) frame(5'b0, 5'b0);
    check("held_drop", int'(h1), 5'b10000);
    keycode = 8'h00;
    step(2);
    press(8'h2C, 5'b10000);
    step(2);
    keycode = 8'h00;
    step(2);

    // Hold A into REPEAT, then switch to S on a tick cycle.
    press(8'h04, 5'b00001);
    for (int f = 1; f <= 11; f++) frame((f == 10) ? 5'b00001 : 5'b00000, 5'b0);
    frame_switch(8'h16, 5'b00100);
    for (int f = 1; f <= 10; f++) frame((f == 10) ? 5'b00100 : 5'b00000, 5'b0);
    check("held_down_after_switch", int'(h1), 5'b00100);
    keycode = 8'h00;
    step(2);

    // Unmapped key releases silently; re-press restarts the delay.
    press(8'h16, 5'b00100);
    for (int f = 1; f <= 3; f++) frame(5'b0, 5'b0);
    keycode = 8'h05;
    step(2);
    check("held_unmapped", int'(h1), 0);
    frame(5'b0, 5'b0);
    keycode = 8'h00;
    step(2);
    check("held_unmapped_to_none", int'(h1), 0);
    press(8'h16, 5'b00100);
    check("held_repress", int'(h1), 5'b00100);
    for (int f = 1; f <= 10; f++) frame((f == 10) ? 5'b00100 : 5'b00000, 5'b0);
    keycode = 8'h00;
    step(2);

    // DAS=1 / ARR=1 instance: one pulse per tick after the press.
    key2 = 8'h04;
    expect_pulse(2, cyc + 1, 5'b00001);
    step(1);
    check("fast_held", int'(h2), 5'b00001);
    for (int f = 1; f <= 5; f++) frame(5'b0, 5'b00001);
    key2 = 8'h00;
    step(2);
    check("fast_held_released", int'(h2), 0);

    step(4);
    check("sb1_drained", q1.size(), 0);
    check("sb2_drained", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
